ysyx_22050019_lsu: RTL and testbench
====================================

# ysyx_22050019_lsu

Load/store unit sitting directly downstream of the execute stage. It takes the EXU result as the effective address and performs one 64-bit-bus memory access per load/store through a valid/ready handshake. It also performs byte-lane alignment, write-mask generation and load sign/zero extension. It holds the pipeline via `lsu_stall` until the access completes, then presents writeback data for loads.

## Interface
Parameters:
- `AW`, 64, address width.
- `DW`, 64, bus data width; fixed at 64, 8 byte lanes.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `ren`  in  1  load request from decode/EXU.
- `wen`  in  1  store request; `ren`/`wen` never both high.
- `funct3`  in  3  bits [1:0] give size (00 B, 01 H, 10 W, 11 D); bit [2] means unsigned load.
- `addr`  in  AW  effective address (EXU `result`).
- `store_data`  in  64  rs2 value, right-aligned.
- `waddr_i`  in  5  load destination register.
- `exu_stall`  in  1  EXU busy; blocks acceptance.
- `mem_valid`  out  1  bus request.
- `mem_ready`  in  1  bus completion.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  AW  `{addr[AW-1:3], 3'b0}`.
- `mem_wmask`  out  8  byte enables.
- `mem_wdata`  out  64  lane-shifted store data.
- `mem_rdata`  in  64  read data, valid with `mem_ready`.
- `lsu_stall`  out  1  hold upstream.
- `lsu_wen`  out  1  load writeback strobe.
- `lsu_waddr`  out  5  writeback register.
- `lsu_wdata`  out  64  extended load data.
- `lsu_misalign`  out  1  misaligned-access pulse (macro-dependent).

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- IDLE: accept when `(ren|wen) & ~exu_stall`. On acceptance, latch `addr`, `funct3`, `store_data`, `waddr_i` and the operation type, then go to REQ.
- REQ: `mem_valid`=1 with the latched fields. On `mem_valid & mem_ready`, capture `mem_rdata` and go to DONE. Request fields stay stable while waiting.
- DONE: lasts one cycle and always returns to IDLE. It never accepts a request, even if `ren`/`wen` are still high.
- `lsu_stall` = (IDLE & (ren|wen) & ~exu_stall) | REQ. It is combinational and low in DONE.
- Let `off` = latched `addr[2:0]` and `n` = 1<<size bytes.
- `mem_wmask` = ((1<<n)-1) << off, truncated to 8 bits. It is 0 for loads.
- `mem_wdata` = `store_data` << (8*off), truncated to 64 bits.
- Load result: `sh` = rdata >> (8*off). Take the low 8·n bits; zero-extend if `funct3[2]`, otherwise sign-extend to 64 bits. A D-size load ignores `funct3[2]`.
- In DONE for a load: `lsu_wen`=1, `lsu_waddr`=latched reg, `lsu_wdata`=result.
- In DONE for a store: `lsu_wen`=0 and `lsu_waddr`=0.
- Outside DONE: `lsu_wen`=0, `lsu_waddr`=0, `lsu_wdata`=0.
- A load to x0 still pulses `lsu_wen` with `lsu_waddr`=0; the regfile ignores it.

## Timing
- Reset values: state IDLE and every output 0 (`mem_valid`, `mem_we`, `mem_addr`, `mem_wmask`, `mem_wdata`, `lsu_wen`, `lsu_waddr`, `lsu_wdata`, `lsu_misalign`). `lsu_stall` is 0 unless a request is present.
- Accepted at cycle T: REQ at T+1. If `mem_ready` is high at T+1, DONE at T+2. Minimum latency is 2 cycles; each wait cycle adds one.
- `lsu_stall` is high from T through the last REQ cycle inclusive.
- Upstream advances at the end of the DONE cycle; a back-to-back request is accepted in the following IDLE cycle.
- `mem_ready` is ignored outside REQ.
- Reset asserted in any state returns to IDLE at the next edge. `mem_valid` drops and no writeback occurs; an aborted bus transaction is acceptable.

## Configuration
- `YSYX_22050019_LSU_ALIGN_CHECK_EN` defined: on acceptance, if `off` is not a multiple of `n`, go IDLE→DONE directly. No bus request is issued, `lsu_misalign`=1 in that DONE cycle, and `lsu_wen`=0.
- Macro not defined: no check and `lsu_misalign` is tied to 0. Byte lanes beyond bit 63 are dropped from the mask, the data, and the load result.

## Test plan
- SB addr 0x8000_0003, store_data 0x...AB, ready immediately -> `mem_addr`=0x8000_0000, `mem_wmask`=0x08, `mem_wdata`[31:24]=0xAB, `lsu_stall` high 2 cycles, `lsu_wen`=0.
- LW signed addr 0x8000_0004, rdata 0x8000_0000_1234_5678, waddr 5 -> DONE: `lsu_wen`=1, `lsu_waddr`=5, `lsu_wdata`=0xFFFF_FFFF_8000_0000. Same access as LWU -> 0x0000_0000_8000_0000.
- LB at off 7 with rdata[63:56]=0x80, `mem_ready` delayed 3 cycles -> `lsu_stall` high 5 cycles, `mem_valid` high 4 cycles, `lsu_wdata`=0xFFFF_FFFF_FFFF_FF80.
- `ren`=1 with `exu_stall`=1 for 2 cycles -> no acceptance and `lsu_stall`=0 during those cycles; acceptance on the first cycle `exu_stall`=0.
- `rst_n` low during REQ -> IDLE next cycle, `mem_valid`=0, no `lsu_wen` pulse.
- Macro on, LW at addr 0x2 -> `mem_valid` never asserted, `lsu_misalign`=1 one cycle, `lsu_wen`=0. Macro off -> bus access at 0x0 with `mem_wmask`=0 and lanes 2..5 used.

Source files
------------

// File: rtl/ysyx_22050019_lsu.sv
// ----------------------------------------------------------------------------
// ysyx_22050019_lsu
//
// Load/store unit placed after the execute stage. Each load or store becomes
// one access on a 64-bit valid/ready memory bus. The unit aligns byte lanes,
// builds the store write mask, and sign- or zero-extends load data. It holds
// the pipeline through lsu_stall until the access completes, then returns the
// writeback data for a load in a one-cycle DONE state.
//
// Optional feature macro: YSYX_22050019_LSU_ALIGN_CHECK_EN
//   When defined, a misaligned access skips the bus entirely, goes straight
//   to DONE and pulses lsu_misalign with no writeback. When undefined, there
//   is no check: lanes above bit 63 are simply dropped, and lsu_misalign is 0.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   ren / wen            load / store request (never both high)
//   funct3               [1:0] size B/H/W/D, [2] unsigned load
//   addr                 effective address from the EXU
//   store_data           rs2 value, right-aligned
//   waddr_i              load destination register
//   exu_stall            EXU busy; blocks acceptance
//   mem_valid/mem_ready  bus handshake
//   mem_we, mem_addr, mem_wmask, mem_wdata, mem_rdata   bus request/response
//   lsu_stall            hold upstream
//   lsu_wen, lsu_waddr, lsu_wdata   load writeback (DONE only)
//   lsu_misalign         misaligned-access pulse
// ----------------------------------------------------------------------------
module ysyx_22050019_lsu #(
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ren,
    input  logic          wen,
    input  logic [2:0]    funct3,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] store_data,
    input  logic [4:0]    waddr_i,
    input  logic          exu_stall,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wmask,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          lsu_stall,
    output logic          lsu_wen,
    output logic [4:0]    lsu_waddr,
    output logic [DW-1:0] lsu_wdata,
    output logic          lsu_misalign
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [2:0]    funct3_q;
    logic [DW-1:0] sdata_q;
    logic [DW-1:0] rdata_q;
    logic [4:0]    waddr_q;
    logic          store_q;
    logic          misalign_q;

    logic          in_idle, in_req, in_done;
    logic          accept;
    logic          in_misalign;
    logic [2:0]    off;
    logic [5:0]    shamt;
    logic [7:0]    size_mask;
    logic [DW-1:0] sh;
    logic [DW-1:0] load_result;
    logic          sext;

    assign in_idle = (state_q == S_IDLE);
    assign in_req  = (state_q == S_REQ);
    assign in_done = (state_q == S_DONE);
    assign accept  = in_idle & (ren | wen) & ~exu_stall;

`ifdef YSYX_22050019_LSU_ALIGN_CHECK_EN
    // Offset must be a multiple of the access size; checked on the incoming
    // request so a faulting access never reaches the bus.
    always_comb begin
        in_misalign = 1'b0;
        case (funct3[1:0])
            2'b00:   in_misalign = 1'b0;
            2'b01:   in_misalign = addr[0];
            2'b10:   in_misalign = |addr[1:0];
            default: in_misalign = |addr[2:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (accept) begin
            misalign_q <= in_misalign;
        end
    end
`else
    assign in_misalign = 1'b0;
    assign misalign_q  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = in_misalign ? S_DONE : S_REQ;
            S_REQ:   if (mem_ready) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            sdata_q  <= '0;
            rdata_q  <= '0;
            waddr_q  <= '0;
            store_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= addr;
                funct3_q <= funct3;
                sdata_q  <= store_data;
                waddr_q  <= waddr_i;
                store_q  <= wen;
            end
            if (in_req && mem_ready) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign off   = addr_q[2:0];
    assign shamt = {off, 3'b000};

    always_comb begin
        size_mask = 8'h01;
        case (funct3_q[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Load data: bring the addressed lane down to bit 0, then extend.
    assign sh   = rdata_q >> shamt;
    assign sext = ~funct3_q[2];

    always_comb begin
        load_result = sh;
        case (funct3_q[1:0])
            2'b00:   load_result = {{56{sext & sh[7]}},  sh[7:0]};
            2'b01:   load_result = {{48{sext & sh[15]}}, sh[15:0]};
            2'b10:   load_result = {{32{sext & sh[31]}}, sh[31:0]};
            default: load_result = sh;
        endcase
    end

    // Bus fields are shown only while a request is outstanding.
    assign mem_valid = in_req;
    assign mem_we    = in_req & store_q;
    assign mem_addr  = in_req ? {addr_q[AW-1:3], 3'b000} : '0;
    assign mem_wmask = (in_req & store_q) ? (size_mask << off) : '0;
    assign mem_wdata = in_req ? (sdata_q << shamt) : '0;

    assign lsu_stall    = accept | in_req;
    assign lsu_wen      = in_done & ~store_q & ~misalign_q;
    assign lsu_waddr    = lsu_wen ? waddr_q : '0;
    assign lsu_wdata    = lsu_wen ? load_result : '0;
    assign lsu_misalign = in_done & misalign_q;

endmodule

// File: tb/tb_ysyx_22050019_lsu.sv
module tb_ysyx_22050019_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [63:0] addr = '0;
    logic [63:0] store_data = '0;
    logic [4:0]  waddr_i = '0;
    logic        exu_stall = 1'b0;
    logic        mem_ready = 1'b0;
    logic [63:0] mem_rdata = '0;

    logic        mem_valid, mem_we, lsu_stall, lsu_wen, lsu_misalign;
    logic [63:0] mem_addr, mem_wdata, lsu_wdata;
    logic [7:0]  mem_wmask;
    logic [4:0]  lsu_waddr;

    ysyx_22050019_lsu #(.AW(64), .DW(64)) dut (
        .clk(clk), .rst_n(rst_n), .ren(ren), .wen(wen), .funct3(funct3),
        .addr(addr), .store_data(store_data), .waddr_i(waddr_i),
        .exu_stall(exu_stall), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lsu_stall(lsu_stall),
        .lsu_wen(lsu_wen), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
        .lsu_misalign(lsu_misalign)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle
    logic        exp_valid, exp_we, exp_stall, exp_wen, exp_mis;
    logic [63:0] exp_addr, exp_wdata, exp_ldata;
    logic [7:0]  exp_mask;
    logic [4:0]  exp_waddr;

    int n_assert = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Per-transaction observations used by the literal pins
    int          stall_cnt = 0, valid_cnt = 0, wen_cnt = 0, mis_cnt = 0;
    logic [63:0] seen_addr = '0, seen_wdata = '0, seen_ldata = '0;
    logic [7:0]  seen_mask = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("mem_valid", mem_valid, exp_valid);
            chk("lsu_stall", lsu_stall, exp_stall);
            chk("lsu_wen", lsu_wen, exp_wen);
            chk("lsu_waddr", lsu_waddr, exp_waddr);
            chk("lsu_wdata", lsu_wdata, exp_ldata);
            chk("lsu_misalign", lsu_misalign, exp_mis);
            if (exp_valid) begin
                chk("mem_we", mem_we, exp_we);
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_wmask", mem_wmask, exp_mask);
                chk("mem_wdata", mem_wdata, exp_wdata);
            end
            if (lsu_stall) stall_cnt++;
            if (mem_valid) begin
                valid_cnt++;
                seen_addr  = mem_addr;
                seen_mask  = mem_wmask;
                seen_wdata = mem_wdata;
            end
            if (lsu_wen) begin
                wen_cnt++;
                seen_ldata = lsu_wdata;
            end
            if (lsu_misalign) mis_cnt++;
        end
    end

    task automatic set_idle();
        exp_valid = 1'b0; exp_we = 1'b0; exp_stall = 1'b0; exp_wen = 1'b0;
        exp_mis = 1'b0; exp_addr = '0; exp_wdata = '0; exp_ldata = '0;
        exp_mask = '0; exp_waddr = '0;
    endtask

    task automatic clear_obs();
        stall_cnt = 0; valid_cnt = 0; wen_cnt = 0; mis_cnt = 0;
    endtask

    // One transaction; called right after a rising edge with the DUT idle.
    task automatic txn(input bit st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] sd, input logic [4:0] rd,
                       input logic [63:0] rdata, input int waits, input int pre);
        int          n, m;
        bit          mis;
        logic [63:0] sh, lowm, res;
        logic [7:0]  emask;
        n = 1 << f3[1:0];
        m = ((1 << n) - 1) << a[2:0];
        emask = st ? m[7:0] : 8'h00;
`ifdef YSYX_22050019_LSU_ALIGN_CHECK_EN
        mis = (int'(a[2:0]) % n) != 0;
`else
        mis = 1'b0;
`endif
        sh = rdata >> (8 * a[2:0]);
        if (n == 8) begin
            res = sh;
        end else begin
            lowm = (64'd1 << (8 * n)) - 64'd1;
            res = sh & lowm;
            if (!f3[2] && sh[8*n-1]) res = res | ~lowm;
        end

        clear_obs();
        ren = !st; wen = st; funct3 = f3; addr = a; store_data = sd;
        waddr_i = rd; mem_ready = 1'b1; mem_rdata = ~rdata;
        set_idle();
        if (pre > 0) begin
            exu_stall = 1'b1;
            for (int i = 0; i < pre; i++) begin
                @(posedge clk); #1;
            end
        end
        exu_stall = 1'b0;
        exp_stall = 1'b1;
        @(posedge clk); #1;
        if (!mis) begin
            for (int i = 0; i <= waits; i++) begin
                mem_ready = (i == waits);
                mem_rdata = (i == waits) ? rdata : ~rdata;
                exp_valid = 1'b1; exp_we = st; exp_stall = 1'b1;
                exp_addr  = {a[63:3], 3'b000};
                exp_mask  = emask;
                exp_wdata = sd << (8 * a[2:0]);
                @(posedge clk); #1;
            end
        end
        mem_ready = 1'b0;
        set_idle();
        exp_wen   = !st && !mis;
        exp_waddr = exp_wen ? rd : 5'd0;
        exp_ldata = exp_wen ? res : 64'd0;
        exp_mis   = mis;
        @(posedge clk); #1;
        ren = 1'b0; wen = 1'b0;
        set_idle();
    endtask

    initial begin
        set_idle();
        check_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // SB at offset 3, immediate ready
        txn(1'b1, 3'b000, 64'h8000_0003, 64'h1234_5678_9ABC_DEAB, 5'd0, 64'd0, 0, 0);
        chk("sb_addr", seen_addr, 64'h8000_0000);
        chk("sb_mask", seen_mask, 8'h08);
        chk("sb_lane", seen_wdata[31:24], 8'hAB);
        chk("sb_stall_cycles", stall_cnt, 2);
        chk("sb_no_wen", wen_cnt, 0);

        // LW signed / LWU, back-to-back
        txn(1'b0, 3'b010, 64'h8000_0004, 64'd0, 5'd5, 64'h8000_0000_1234_5678, 0, 0);
        chk("lw_data", seen_ldata, 64'hFFFF_FFFF_8000_0000);
        chk("lw_wen_once", wen_cnt, 1);
        txn(1'b0, 3'b110, 64'h8000_0004, 64'd0, 5'd5, 64'h8000_0000_1234_5678, 0, 0);
        chk("lwu_data", seen_ldata, 64'h0000_0000_8000_0000);

        // LB at offset 7 with three wait cycles
        txn(1'b0, 3'b000, 64'h8000_0107, 64'd0, 5'd9, 64'h80AA_BBCC_DDEE_FF11, 3, 0);
        chk("lb_stall_cycles", stall_cnt, 5);
        chk("lb_valid_cycles", valid_cnt, 4);
        chk("lb_data", seen_ldata, 64'hFFFF_FFFF_FFFF_FF80);

        // LH held off by exu_stall for two cycles
        txn(1'b0, 3'b001, 64'h0010_0006, 64'd0, 5'd12, 64'h7FFE_0000_0000_0000, 0, 2);
        chk("lh_stall_cycles", stall_cnt, 2);
        chk("lh_data", seen_ldata, 64'h0000_0000_0000_7FFE);

        // Other sizes
        txn(1'b1, 3'b011, 64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 5'd0, 64'd0, 1, 0);
        chk("sd_mask", seen_mask, 8'hFF);
        txn(1'b1, 3'b001, 64'h8000_000A, 64'hFFFF_FFFF_FFFF_1234, 5'd0, 64'd0, 0, 0);
        chk("sh_mask", seen_mask, 8'h0C);
        chk("sh_wdata", seen_wdata, 64'hFFFF_FFFF_1234_0000);
        txn(1'b0, 3'b100, 64'h8000_0015, 64'd0, 5'd31, 64'h0000_F000_0000_0000, 2, 0);
        chk("lbu_data", seen_ldata, 64'h0000_0000_0000_00F0);
        txn(1'b0, 3'b101, 64'h8000_0002, 64'd0, 5'd7, 64'h0000_0000_9ABC_0000, 0, 0);
        txn(1'b0, 3'b011, 64'h8000_0020, 64'd0, 5'd0, 64'hF0E1_D2C3_B4A5_9687, 0, 0);
        chk("ld_x0_wen", wen_cnt, 1);

        // Reset while the request is outstanding
        clear_obs();
        ren = 1'b1; funct3 = 3'b010; addr = 64'h8000_0010; store_data = '0;
        waddr_i = 5'd3; mem_ready = 1'b0;
        set_idle(); exp_stall = 1'b1;
        @(posedge clk); #1;
        exp_valid = 1'b1; exp_stall = 1'b1; exp_addr = 64'h8000_0010;
        rst_n = 1'b0; ren = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; set_idle();
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_ready = 1'b0;
        chk("rst_valid_cycles", valid_cnt, 1);
        chk("rst_no_wen", wen_cnt, 0);

        // Misaligned LW and SW
        txn(1'b0, 3'b010, 64'h0000_0002, 64'd0, 5'd4, 64'h1111_2233_4455_6677, 0, 0);
`ifdef YSYX_22050019_LSU_ALIGN_CHECK_EN
        chk("mis_lw_no_bus", valid_cnt, 0);
        chk("mis_lw_pulse", mis_cnt, 1);
        chk("mis_lw_no_wen", wen_cnt, 0);
`else
        chk("mis_lw_addr", seen_addr, 64'h0);
        chk("mis_lw_mask", seen_mask, 8'h00);
        chk("mis_lw_data", seen_ldata, 64'h0000_0000_2233_4455);
`endif
        txn(1'b1, 3'b010, 64'h8000_0006, 64'h0000_0000_A1B2_C3D4, 5'd0, 64'd0, 0, 0);
`ifdef YSYX_22050019_LSU_ALIGN_CHECK_EN
        chk("mis_sw_no_bus", valid_cnt, 0);
`else
        chk("mis_sw_mask", seen_mask, 8'hC0);
        chk("mis_sw_wdata", seen_wdata, 64'hC3D4_0000_0000_0000);
`endif

        @(posedge clk); #1;
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
